// File: rtl/uart_tx.sv
// uart_tx: serializes a parallel word on txd as a start/data(LSB first)/stop frame behind a valid/ready handshake.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 txd,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [BW-1:0]          bits, bits_n;
  logic [DATA_BITS-1:0]   sh, sh_n;
  logic                   txd_n, bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bits  <= '0;
      sh    <= '0;
      txd   <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bits  <= bits_n;
      sh    <= sh_n;
      txd   <= txd_n;
    end
  end

  // txd is registered from the next-state view so the start bit appears the cycle after acceptance
  always_comb begin
    bit_end = cnt == CNT_LAST;
    state_n = state;
    bits_n  = bits;
    sh_n    = sh;
    cnt_n   = (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
    case (state)
      IDLE: if (tx_valid) begin
        state_n = START;
        sh_n    = tx_data;
      end
      START: if (bit_end) state_n = DATA;
      DATA: if (bit_end) begin
        sh_n    = sh >> 1;
        bits_n  = bits == DATA_LAST ? '0 : bits + 1'b1;
        state_n = bits == DATA_LAST ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        bits_n  = bits == STOP_LAST ? '0 : bits + 1'b1;
        state_n = bits == STOP_LAST ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
    txd_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
  end

  assign tx_ready = state == IDLE;
  assign busy     = ~tx_ready;
endmodule
